// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner driven off the board clkdiv bus.
// Optional leading-zero blanking in hex mode is built when SEG7_LZ_SUPPRESS_EN is defined.
module seg7_scan #(
   parameter int SCAN_BIT  = 17,
   parameter int BLINK_BIT = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] clkdiv,
   input  logic        mode,
   input  logic [31:0] disp_data,
   input  logic [63:0] seg_raw,
   input  logic [7:0]  dp,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic [2:0]  digit_idx
);

   function automatic logic [6:0] hex_decode(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'h0:    r = 7'h40;
         4'h1:    r = 7'h79;
         4'h2:    r = 7'h24;
         4'h3:    r = 7'h30;
         4'h4:    r = 7'h19;
         4'h5:    r = 7'h12;
         4'h6:    r = 7'h02;
         4'h7:    r = 7'h78;
         4'h8:    r = 7'h00;
         4'h9:    r = 7'h10;
         4'hA:    r = 7'h08;
         4'hB:    r = 7'h03;
         4'hC:    r = 7'h46;
         4'hD:    r = 7'h21;
         4'hE:    r = 7'h06;
         default: r = 7'h0E;
      endcase
      return r;
   endfunction

   logic        prev_q, prev_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  an_q, an_d;
   logic [7:0]  seg_q, seg_d;
   logic        frm_mode_q, frm_mode_d;
   logic [31:0] frm_data_q, frm_data_d;
   logic [63:0] frm_raw_q, frm_raw_d;
   logic [7:0]  frm_dp_q, frm_dp_d;
   logic [7:0]  frm_blink_q, frm_blink_d;

   logic        tick;
   logic        wrap;
   logic [2:0]  nxt_idx;
   logic        src_mode;
   logic [31:0] src_data;
   logic [63:0] src_raw;
   logic [7:0]  src_dp;
   logic [7:0]  src_blink;
   logic [4:0]  nib_lsb;
   logic [5:0]  byte_lsb;
   logic [3:0]  nibble;
   logic [6:0]  seg_lo;
   logic [7:0]  hex_seg;
   logic [7:0]  raw_seg;
   logic        blank;
   logic        unused_clkdiv_bits;

   // Only two clkdiv bits matter; fold the rest so the bus is fully consumed.
   assign unused_clkdiv_bits = ^clkdiv;

   // The wrap tick shows digit 0 of the frame being latched, so it reads the live inputs.
   always_comb begin
      tick      = clkdiv[SCAN_BIT] & ~prev_q;
      wrap      = tick & (idx_q == 3'd7);
      nxt_idx   = idx_q + 3'd1;
      src_mode  = wrap ? mode       : frm_mode_q;
      src_data  = wrap ? disp_data  : frm_data_q;
      src_raw   = wrap ? seg_raw    : frm_raw_q;
      src_dp    = wrap ? dp         : frm_dp_q;
      src_blink = wrap ? blink_mask : frm_blink_q;
      nib_lsb   = {nxt_idx, 2'b00};
      byte_lsb  = {nxt_idx, 3'b000};
      nibble    = src_data[nib_lsb +: 4];
      raw_seg   = src_raw[byte_lsb +: 8];
      blank     = src_blink[nxt_idx] & clkdiv[BLINK_BIT];
   end

`ifdef SEG7_LZ_SUPPRESS_EN
   logic [7:0] zero_from;

   // zero_from[k]: nibbles k..7 are all zero; digit 0 always shows.
   always_comb begin
      zero_from    = 8'h00;
      zero_from[7] = (src_data[31:28] == 4'h0);
      for (int k = 6; k >= 0; k--) begin
         zero_from[k] = zero_from[k+1] & (src_data[4*k +: 4] == 4'h0);
      end
      if ((nxt_idx != 3'd0) && zero_from[nxt_idx]) begin
         seg_lo = 7'h7F;
      end else begin
         seg_lo = hex_decode(nibble);
      end
   end
`else
   assign seg_lo = hex_decode(nibble);
`endif

   assign hex_seg = {~src_dp[nxt_idx], seg_lo};

   always_comb begin
      prev_d      = clkdiv[SCAN_BIT];
      idx_d       = idx_q;
      an_d        = an_q;
      seg_d       = seg_q;
      frm_mode_d  = frm_mode_q;
      frm_data_d  = frm_data_q;
      frm_raw_d   = frm_raw_q;
      frm_dp_d    = frm_dp_q;
      frm_blink_d = frm_blink_q;
      if (wrap) begin
         frm_mode_d  = mode;
         frm_data_d  = disp_data;
         frm_raw_d   = seg_raw;
         frm_dp_d    = dp;
         frm_blink_d = blink_mask;
      end
      if (tick) begin
         idx_d = nxt_idx;
         an_d  = ~(8'h01 << nxt_idx);
         if (blank) begin
            seg_d = 8'hFF;
         end else if (src_mode) begin
            seg_d = raw_seg;
         end else begin
            seg_d = hex_seg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= 1'b0;
         idx_q       <= 3'd7;
         an_q        <= 8'hFF;
         seg_q       <= 8'hFF;
         frm_mode_q  <= 1'b0;
         frm_data_q  <= 32'h0;
         frm_raw_q   <= 64'h0;
         frm_dp_q    <= 8'h00;
         frm_blink_q <= 8'h00;
      end else begin
         prev_q      <= prev_d;
         idx_q       <= idx_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         frm_mode_q  <= frm_mode_d;
         frm_data_q  <= frm_data_d;
         frm_raw_q   <= frm_raw_d;
         frm_dp_q    <= frm_dp_d;
         frm_blink_q <= frm_blink_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a fast scan bit (2) and a hand-driven blink phase on bit 31.
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] clkdiv;
   logic        mode;
   logic [31:0] disp_data;
   logic [63:0] seg_raw;
   logic [7:0]  dp;
   logic [7:0]  blink_mask;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic [2:0]  digit_idx;

   logic [30:0] cnt = '0;
   logic        blink_ph;

   int n_vec = 0;
   int n_bad = 0;

`ifdef SEG7_LZ_SUPPRESS_EN
   localparam logic [7:0] ZERO_HI = 8'hFF;
`else
   localparam logic [7:0] ZERO_HI = 8'hC0;
`endif

   seg7_scan #(.SCAN_BIT(2), .BLINK_BIT(31)) dut (
      .clk        (clk),
      .rst        (rst),
      .clkdiv     (clkdiv),
      .mode       (mode),
      .disp_data  (disp_data),
      .seg_raw    (seg_raw),
      .dp         (dp),
      .blink_mask (blink_mask),
      .an         (an),
      .seg        (seg),
      .digit_idx  (digit_idx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 31'd1;
   assign clkdiv = {blink_ph, cnt};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_tick(output int cycles);
      logic [2:0] old;
      old    = digit_idx;
      cycles = 0;
      while (digit_idx == old && cycles < 64) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= 64) chk("tick_timeout", 32'(cycles), 32'd0);
   endtask

   task automatic step(input string tag, input int n, input logic [7:0] exp_seg, input bit chk_gap);
      int c;
      logic [7:0] exp_an;
      wait_tick(c);
      exp_an = 8'hFF ^ (8'h01 << n);
      chk($sformatf("%s_idx%0d", tag, n), 32'(digit_idx), 32'(n));
      chk($sformatf("%s_an%0d", tag, n), 32'(an), 32'(exp_an));
      chk($sformatf("%s_seg%0d", tag, n), 32'(seg), 32'(exp_seg));
      if (chk_gap) chk($sformatf("%s_gap%0d", tag, n), 32'(c), 32'd8);
   endtask

   logic [7:0] hex_exp [8] = '{8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
   logic [7:0] raw_exp [8] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

   initial begin
      rst        = 1'b1;
      blink_ph   = 1'b0;
      mode       = 1'b0;
      disp_data  = 32'h89AB_CDEF;
      seg_raw    = 64'h0102_0408_1020_4080;
      dp         = 8'h01;
      blink_mask = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_an", 32'(an), 32'hFF);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_idx", 32'(digit_idx), 32'd7);
      rst = 1'b0;

      // hex scan, first frame after reset
      for (int i = 0; i < 8; i++) step("hex", i, hex_exp[i], i != 0);

      // snapshot: data change after digit 3 must not leak into digits 4..7
      for (int i = 0; i < 4; i++) step("snap", i, hex_exp[i], 1'b1);
      disp_data = 32'h0;
      dp        = 8'h00;
      for (int i = 4; i < 8; i++) step("snap", i, hex_exp[i], 1'b1);
      step("zero", 0, 8'hC0, 1'b1);
      for (int i = 1; i < 8; i++) step("zero", i, ZERO_HI, 1'b1);

      // raw mode, dp ignored
      mode = 1'b1;
      dp   = 8'hFF;
      for (int i = 0; i < 8; i++) step("raw", i, raw_exp[i], 1'b1);

      // blink digit 2; digit 3 not masked so blink phase has no effect there
      mode       = 1'b0;
      dp         = 8'h00;
      disp_data  = 32'h89AB_CDEF;
      blink_mask = 8'h04;
      step("blk", 0, 8'h8E, 1'b1);
      step("blk", 1, 8'h86, 1'b1);
      blink_ph = 1'b1;
      step("blk", 2, 8'hFF, 1'b1);
      step("blk", 3, 8'hC6, 1'b1);
      blink_ph = 1'b0;
      for (int i = 4; i < 8; i++) step("blk", i, hex_exp[i] | 8'h80, 1'b1);
      step("noblk", 0, 8'h8E, 1'b1);
      step("noblk", 1, 8'h86, 1'b1);
      step("noblk", 2, 8'hA1, 1'b1);
      for (int i = 3; i < 8; i++) step("noblk", i, hex_exp[i] | 8'h80, 1'b1);

      // leading zeros
      blink_mask = 8'h00;
      disp_data  = 32'h0000_0050;
      step("lz", 0, 8'hC0, 1'b1);
      step("lz", 1, 8'h92, 1'b1);
      for (int i = 2; i < 5; i++) step("lz", i, ZERO_HI, 1'b1);

      // reset mid-frame at digit 4
      rst = 1'b1;
      #1;
      chk("mid_rst_an", 32'(an), 32'hFF);
      chk("mid_rst_seg", 32'(seg), 32'hFF);
      chk("mid_rst_idx", 32'(digit_idx), 32'd7);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      step("post_rst", 0, 8'hC0, 1'b0);
      step("post_rst", 1, 8'h92, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
